// File: rtl/city_sprite_drawer_pkg.sv
// Shared constants for the city sprite drawer: screen limits, colours,
// and the two 16x8 one-bit city bitmaps (bit 15 of each row is column 0).
// CITY_ROM flattens both bitmaps into the 256x1 ROM image addressed as
// {sel,row[2:0],col[3:0]}, where sel=1 selects the intact bitmap.
package missile_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int COLOR_W  = 3;
  localparam int SPR_W    = 16;
  localparam int SPR_H    = 8;

  localparam logic [COLOR_W-1:0] CITY_COLOR   = 3'b010;
  localparam logic [COLOR_W-1:0] RUBBLE_COLOR = 3'b100;
  localparam logic [COLOR_W-1:0] BG_COLOR     = 3'b000;

  // popcount 80
  localparam logic [0:7][15:0] CITY_INTACT = {
    16'h0180, 16'h03C0, 16'h33CC, 16'h7BDE,
    16'h7FFE, 16'hFFFF, 16'hFFFF, 16'hF00F
  };

  // rows 6-7 solid, popcount 32
  localparam logic [0:7][15:0] CITY_RUBBLE = {
    16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF
  };

  function automatic logic sprite_bit(input logic sel, input logic [2:0] row,
                                      input logic [3:0] col);
    if (sel) sprite_bit = CITY_INTACT[row][4'd15 - col];
    else     sprite_bit = CITY_RUBBLE[row][4'd15 - col];
  endfunction

  function automatic logic [255:0] build_rom();
    logic [255:0] r;
    r = '0;
    for (int a = 0; a < 256; a++) begin
      r[a] = sprite_bit(a[7], a[6:4], a[3:0]);
    end
    return r;
  endfunction

  localparam logic [255:0] CITY_ROM = build_rom();

endpackage

// File: rtl/city_sprite_drawer_if.sv
// Request/pixel bundle between the draw FSM (master) and one city sprite
// drawer (slave).
//   start, base_x, base_y, color, status : draw request, latched on start
//   out_x, out_y, out_color, plot        : one pixel per plot strobe
//   busy, done                           : drawer activity / completion pulse
interface city_sprite_drawer_if;
  import missile_pkg::*;

  logic               start;
  logic [8:0]         base_x;
  logic [7:0]         base_y;
  logic [COLOR_W-1:0] color;
  logic               status;

  logic [8:0]         out_x;
  logic [7:0]         out_y;
  logic [COLOR_W-1:0] out_color;
  logic               plot;
  logic               busy;
  logic               done;

  modport master (
    output start, base_x, base_y, color, status,
    input  out_x, out_y, out_color, plot, busy, done
  );

  modport slave (
    input  start, base_x, base_y, color, status,
    output out_x, out_y, out_color, plot, busy, done
  );

endinterface

// File: rtl/city_sprite_rom.sv
// Synchronous 256x1 city bitmap ROM, one-cycle read latency.
//   clk  : clock
//   addr : {sel,row[2:0],col[3:0]}, sel=1 intact, sel=0 rubble
//   data : bitmap bit, valid the cycle after addr is presented
module city_sprite_rom
  import missile_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] addr,
  output logic       data
);

  always_ff @(posedge clk) begin
    data <= CITY_ROM[addr];
  end

endmodule

// File: rtl/city_sprite_drawer.sv
// Streams the 16x8 pixels of one city sprite (intact or rubble) anchored at
// (base_x, base_y), one pixel every two cycles, row-major from top-left.
// Pixels off the right/bottom of the screen are suppressed without changing
// timing. With OPAQUE=0 clear bitmap bits produce no plot.
//   clk : clock
//   rst : asynchronous active-low reset
//   bus : slave side of city_sprite_drawer_if
//
// state | meaning
// IDLE  | waiting for start; inputs latched when it arrives
// FETCH | ROM address {status,row,col} presented
// EMIT  | ROM bit valid; pixel registered, scan position advanced
// DONE  | done pulse issued, busy dropped
module city_sprite_drawer
  import missile_pkg::*;
#(
  parameter bit OPAQUE = 1'b0
) (
  input logic clk,
  input logic rst,
  city_sprite_drawer_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EMIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state;
  logic [8:0]         base_x_l;
  logic [7:0]         base_y_l;
  logic [COLOR_W-1:0] color_l;
  logic               status_l;
  logic [2:0]         row;
  logic [3:0]         col;

  logic [8:0]         out_x;
  logic [7:0]         out_y;
  logic [COLOR_W-1:0] out_color;
  logic               plot;
  logic               busy;
  logic               done;

  logic               rom_data;
  logic [9:0]         sum_x;
  logic [9:0]         sum_y;
  logic               on_screen;
  logic               last_px;
  logic               draw_px;
  logic [COLOR_W-1:0] px_color;

  city_sprite_rom u_rom (
    .clk  (clk),
    .addr ({status_l, row, col}),
    .data (rom_data)
  );

  // 10-bit sums so that base_x up to 511 plus col cannot wrap back on-screen
  assign sum_x     = {1'b0, base_x_l} + {6'd0, col};
  assign sum_y     = {2'b0, base_y_l} + {7'd0, row};
  assign on_screen = (sum_x < 10'(SCREEN_W)) && (sum_y < 10'(SCREEN_H));
  assign last_px   = (row == 3'(SPR_H - 1)) && (col == 4'(SPR_W - 1));
  assign draw_px   = on_screen && (rom_data || OPAQUE);
  assign px_color  = !rom_data ? BG_COLOR : (status_l ? color_l : RUBBLE_COLOR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      base_x_l  <= '0;
      base_y_l  <= '0;
      color_l   <= '0;
      status_l  <= 1'b0;
      row       <= '0;
      col       <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_color <= '0;
      plot      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            base_x_l <= bus.base_x;
            base_y_l <= bus.base_y;
            color_l  <= bus.color;
            status_l <= bus.status;
            row      <= '0;
            col      <= '0;
            busy     <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: state <= S_EMIT;
        S_EMIT: begin
          // out_* only move on a plotted pixel so they hold while plot=0
          if (draw_px) begin
            out_x     <= sum_x[8:0];
            out_y     <= sum_y[7:0];
            out_color <= px_color;
            plot      <= 1'b1;
          end
          if (last_px) begin
            state <= S_DONE;
          end else begin
            col <= col + 4'd1;
            if (col == 4'(SPR_W - 1)) row <= row + 3'd1;
            state <= S_FETCH;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_x     = out_x;
  assign bus.out_y     = out_y;
  assign bus.out_color = out_color;
  assign bus.plot      = plot;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule

// File: tb/tb_city_sprite_drawer.sv
// Scoreboard bench for city_sprite_drawer: two instances (OPAQUE=0 and 1).
// Each launched draw pushes its expected pixels (coordinates, colour, cycle)
// and done cycle into per-instance queues; a negedge monitor pops on every
// plot/done and compares.
module tb_city_sprite_drawer;

  typedef struct {
    int x;
    int y;
    int c;
    int t;
  } px_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  city_sprite_drawer_if bus0 ();
  city_sprite_drawer_if bus1 ();

  city_sprite_drawer #(.OPAQUE(1'b0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  city_sprite_drawer #(.OPAQUE(1'b1)) u_dut_op (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  // Reference bitmaps, bit 15 = leftmost column
  logic [15:0] tb_intact [8] = '{16'h0180, 16'h03C0, 16'h33CC, 16'h7BDE,
                                 16'h7FFE, 16'hFFFF, 16'hFFFF, 16'hF00F};
  logic [15:0] tb_rubble [8] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};

  px_t q0[$];
  px_t q1[$];
  int  d0[$];
  int  d1[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input bit ok, input string detail);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: %s", name, detail);
    end
  endfunction

  // Expected pixel stream of one draw whose start edge leaves cyc == ts.
  // Pixel k has plot high in cycle 3+2k, i.e. cyc == ts+2+2k at the negedge;
  // done in cycle 258, i.e. cyc == ts+257.
  task automatic model(input int inst, input int bx, input int by, input int c,
                       input int st, input int ts);
    px_t e;
    for (int k = 0; k < 128; k++) begin
      int r;
      int cl;
      bit b;
      r   = k / 16;
      cl  = k % 16;
      b   = st ? tb_intact[r][15-cl] : tb_rubble[r][15-cl];
      e.x = bx + cl;
      e.y = by + r;
      e.t = ts + 2 + 2 * k;
      e.c = b ? (st ? c : 4) : 0;
      if (e.x >= 320 || e.y >= 240) continue;
      if (!b && inst == 0) continue;
      if (inst == 0) q0.push_back(e);
      else           q1.push_back(e);
    end
    if (inst == 0) d0.push_back(ts + 257);
    else           d1.push_back(ts + 257);
  endtask

  always @(negedge clk) begin
    px_t e;
    bit  ok;
    if (rst) begin
      if (bus0.plot) begin
        ok = q0.size() > 0;
        if (ok) e = q0.pop_front();
        check("plot_op0", ok && bus0.out_x == e.x && bus0.out_y == e.y &&
              bus0.out_color == e.c && cyc == e.t,
              $sformatf("got x=%0d y=%0d c=%0d t=%0d required x=%0d y=%0d c=%0d t=%0d (queued=%0d)",
                        bus0.out_x, bus0.out_y, bus0.out_color, cyc, e.x, e.y, e.c, e.t, ok));
      end
      if (bus1.plot) begin
        ok = q1.size() > 0;
        if (ok) e = q1.pop_front();
        check("plot_op1", ok && bus1.out_x == e.x && bus1.out_y == e.y &&
              bus1.out_color == e.c && cyc == e.t,
              $sformatf("got x=%0d y=%0d c=%0d t=%0d required x=%0d y=%0d c=%0d t=%0d (queued=%0d)",
                        bus1.out_x, bus1.out_y, bus1.out_color, cyc, e.x, e.y, e.c, e.t, ok));
      end
      if (bus0.done) begin
        ok = d0.size() > 0;
        e.t = ok ? d0.pop_front() : -1;
        check("done_op0", ok && cyc == e.t,
              $sformatf("got done at t=%0d required t=%0d", cyc, e.t));
      end
      if (bus1.done) begin
        ok = d1.size() > 0;
        e.t = ok ? d1.pop_front() : -1;
        check("done_op1", ok && cyc == e.t,
              $sformatf("got done at t=%0d required t=%0d", cyc, e.t));
      end
    end
  end

  task automatic launch(input int inst, input int bx, input int by, input int c,
                        input int st, input bit hold);
    @(negedge clk);
    t0 = cyc + 1;
    if (inst == 0) begin
      bus0.base_x = 9'(bx); bus0.base_y = 8'(by); bus0.color = 3'(c);
      bus0.status = st[0];  bus0.start  = 1'b1;
    end else begin
      bus1.base_x = 9'(bx); bus1.base_y = 8'(by); bus1.color = 3'(c);
      bus1.status = st[0];  bus1.start  = 1'b1;
    end
    model(inst, bx, by, c, st, t0);
    @(negedge clk);
    check("busy_after_start", (inst == 0) ? bus0.busy : bus1.busy,
          $sformatf("got busy=0 in cycle 1, required 1 (inst %0d)", inst));
    if (!hold) begin
      bus0.start = 1'b0;
      bus1.start = 1'b0;
    end
  endtask

  task automatic drain(input int inst, input string name);
    int n;
    n = 0;
    while (((inst == 0) ? d0.size() : d1.size()) != 0 && n < 700) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_done_seen"}, n < 700,
          $sformatf("got no done within %0d cycles, required done", n));
    check({name, "_all_plots"}, ((inst == 0) ? q0.size() : q1.size()) == 0,
          $sformatf("got %0d expected pixels never plotted, required 0",
                    (inst == 0) ? q0.size() : q1.size()));
    check({name, "_idle_busy"}, ((inst == 0) ? bus0.busy : bus1.busy) == 1'b0,
          "got busy=1 after done, required 0");
  endtask

  function automatic bit outs_zero();
    return bus0.out_x == 0 && bus0.out_y == 0 && bus0.out_color == 0 &&
           !bus0.plot && !bus0.busy && !bus0.done &&
           bus1.out_x == 0 && bus1.out_y == 0 && bus1.out_color == 0 &&
           !bus1.plot && !bus1.busy && !bus1.done;
  endfunction

  initial begin
    int ts;
    bus0.start = 1'b0; bus0.base_x = '0; bus0.base_y = '0; bus0.color = '0; bus0.status = 1'b0;
    bus1.start = 1'b0; bus1.base_x = '0; bus1.base_y = '0; bus1.color = '0; bus1.status = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", outs_zero(),
          $sformatf("got x=%0d y=%0d c=%0d plot=%0d busy=%0d done=%0d, required all 0",
                    bus0.out_x, bus0.out_y, bus0.out_color, bus0.plot, bus0.busy, bus0.done));
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);

    launch(0, 80, 200, 2, 1, 1'b0);  drain(0, "intact");
    launch(0, 80, 200, 2, 0, 1'b0);  drain(0, "rubble");
    launch(0, 312, 236, 2, 1, 1'b0); drain(0, "clip");
    launch(1, 0, 0, 2, 1, 1'b0);     drain(1, "opaque");
    launch(1, 310, 235, 5, 0, 1'b0); drain(1, "opaque_clip");

    // restart attempt in cycle 50 plus input changes mid-draw
    launch(0, 40, 100, 5, 1, 1'b0);
    while (cyc < t0 + 49) @(negedge clk);
    bus0.start = 1'b1; bus0.base_x = 9'd200; bus0.base_y = 8'd9;
    bus0.status = 1'b0; bus0.color = 3'd7;
    @(negedge clk);
    bus0.start = 1'b0;
    drain(0, "midchange");

    // start held high retriggers on the first IDLE cycle after done
    launch(0, 300, 10, 6, 1, 1'b1);
    ts = t0;
    model(0, 300, 10, 6, 1, ts + 258);
    while (cyc < ts + 258) @(negedge clk);
    bus0.start = 1'b0;
    drain(0, "retrigger");

    // reset in cycle 100 aborts the draw
    launch(0, 100, 50, 3, 1, 1'b0);
    while (cyc < t0 + 99) @(negedge clk);
    #2 rst = 1'b0;
    q0.delete();
    d0.delete();
    @(negedge clk);
    #1;
    check("reset_abort", outs_zero(),
          $sformatf("got x=%0d y=%0d c=%0d plot=%0d busy=%0d done=%0d, required all 0",
                    bus0.out_x, bus0.out_y, bus0.out_color, bus0.plot, bus0.busy, bus0.done));
    repeat (3) @(negedge clk);
    check("reset_hold_no_done", !bus0.done && !bus0.plot,
          $sformatf("got done=%0d plot=%0d while in reset, required 0", bus0.done, bus0.plot));
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("after_reset_idle", !bus0.done && !bus0.busy,
          $sformatf("got done=%0d busy=%0d after release, required 0", bus0.done, bus0.busy));
    launch(0, 100, 50, 3, 1, 1'b0);
    drain(0, "post_reset");

    for (int i = 0; i < 8; i++) begin
      int inst;
      inst = i % 2;
      launch(inst, $urandom_range(0, 511), $urandom_range(0, 255),
             $urandom_range(0, 7), $urandom_range(0, 1), 1'b0);
      drain(inst, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: got simulation still running at 1ms, required finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
